// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO accumulator and shift-add multiplier sequencer with MF/MT access (optional MSUBU via HILO_MSUB_EN)
module hilo_unit #(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [63:0] mulIn,
    output logic [5:0]  mulSignal,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MADDU = 6'b000001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MSUBU = 6'b000101;
    localparam logic [5:0] M_IDLE  = 6'b000000;
    localparam logic [5:0] M_OUT   = 6'b111111;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FETCH, WRITE} state_t;
    typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]  mul_signal_q, mul_signal_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, data_out_q, data_out_d;
    logic        done_q, done_d;
    logic [63:0] acc, nxt;

    // Next-state, operand capture and HI/LO update for every state
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        mul_signal_d = mul_signal_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        data_out_d   = data_out_q;
        done_d       = 1'b0;
        acc          = {hi_q, lo_q};
`ifdef HILO_MSUB_EN
        nxt = (op_q == OP_MSUB) ? acc - mulIn : (op_q == OP_MADD) ? acc + mulIn : mulIn;
`else
        nxt = (op_q == OP_MADD) ? acc + mulIn : mulIn;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (Signal)
                        F_MFHI: begin
                            data_out_d = hi_q;
                            done_d     = 1'b1;
                        end
                        F_MFLO: begin
                            data_out_d = lo_q;
                            done_d     = 1'b1;
                        end
                        F_MTHI: begin
                            hi_d   = dataA;
                            done_d = 1'b1;
                        end
                        F_MTLO: begin
                            lo_d   = dataA;
                            done_d = 1'b1;
                        end
                        F_MULTU: begin
                            op_d         = OP_MULT;
                            state_d      = LOAD;
                            mul_signal_d = F_MULTU;
                        end
                        F_MADDU: begin
                            op_d         = OP_MADD;
                            state_d      = LOAD;
                            mul_signal_d = F_MADDU;
                        end
`ifdef HILO_MSUB_EN
                        F_MSUBU: begin
                            op_d         = OP_MSUB;
                            state_d      = LOAD;
                            mul_signal_d = F_MULTU;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                cnt_d        = '0;
                state_d      = RUN;
                mul_signal_d = M_IDLE;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CYCLES - 1)) begin
                    state_d      = FETCH;
                    mul_signal_d = M_OUT;
                end
            end
            FETCH: begin
                state_d      = WRITE;
                mul_signal_d = M_IDLE;
            end
            WRITE: begin
                {hi_d, lo_d} = nxt;
                state_d      = IDLE;
                done_d       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_MULT;
            cnt_q        <= '0;
            mul_signal_q <= M_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            data_out_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            mul_signal_q <= mul_signal_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            data_out_q   <= data_out_d;
            done_q       <= done_d;
        end
    end

    assign mulSignal = mul_signal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dataOut   = data_out_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed self-checking bench for hilo_unit
module tb_hilo_unit;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MADDU = 6'b000001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MSUBU = 6'b000101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  Signal = '0;
    logic [31:0] dataA = '0;
    logic [63:0] mulIn = '0;
    logic [5:0]  mulSignal;
    logic [31:0] hi, lo, dataOut;
    logic        busy, done;
    int checks = 0;
    int errors = 0;

    hilo_unit #(.CYCLES(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .mulIn(mulIn), .mulSignal(mulSignal),
        .hi(hi), .lo(lo), .dataOut(dataOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Issue a one-cycle request; returns at the negedge after the accepting edge
    task automatic issue(input logic [5:0] sig, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1;
        Signal = sig;
        dataA = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a multiply and wait (bounded) for done; returns at the negedge where done is high
    task automatic run_mul(input logic [5:0] sig, input logic [63:0] prod, output int cyc);
        mulIn = prod;
        issue(sig, 32'h0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL mul_timeout sig=%b done=%b expected 1", sig, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({hi, lo, dataOut, mulSignal, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state hi=%h lo=%h dout=%h ms=%b busy=%b done=%b expected all 0",
                     hi, lo, dataOut, mulSignal, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_multu;
        logic [5:0] exp_ms;
        int bad = 0;
        mulIn = 64'hFFFF_FFFE_0000_0001;
        @(negedge clk);
        start = 1'b1;
        Signal = F_MULTU;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_ms = (k == 1) ? F_MULTU : (k == 34) ? 6'b111111 : 6'b000000;
            if (mulSignal !== exp_ms || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL multu_seq cycle=%0d ms=%b busy=%b done=%b expected ms=%b busy=1 done=0",
                         k, mulSignal, busy, done, exp_ms);
            end
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge clk);
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multu_result hi=%h lo=%h done=%b busy=%b expected fffffffe 00000001 1 0",
                     hi, lo, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic test_mt_maddu;
        int cyc;
        issue(F_MTHI, 32'h1);
        checks++;
        if (hi !== 32'h1 || done !== 1'b1) begin
            errors++;
            $display("FAIL mthi hi=%h done=%b expected 1 1", hi, done);
        end
        issue(F_MTLO, 32'hFFFF_FFFF);
        checks++;
        if (lo !== 32'hFFFF_FFFF || done !== 1'b1) begin
            errors++;
            $display("FAIL mtlo lo=%h done=%b expected ffffffff 1", lo, done);
        end
        run_mul(F_MADDU, 64'h1, cyc);
        checks++;
        if (hi !== 32'h2 || lo !== 32'h0 || cyc != 36) begin
            errors++;
            $display("FAIL maddu_carry hi=%h lo=%h cycles=%0d expected 2 0 36", hi, lo, cyc);
        end
    endtask

    task automatic test_mf;
        issue(F_MFHI, 32'h0);
        checks++;
        if (dataOut !== 32'h2 || done !== 1'b1) begin
            errors++;
            $display("FAIL mfhi dout=%h done=%b expected 2 1", dataOut, done);
        end
        issue(F_MFLO, 32'h0);
        checks++;
        if (dataOut !== 32'h0 || done !== 1'b1) begin
            errors++;
            $display("FAIL mflo dout=%h done=%b expected 0 1", dataOut, done);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc = 1;
        mulIn = 64'h0000_0007_0000_0009;
        issue(F_MULTU, 32'h0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        Signal = F_MTLO;
        dataA = 32'h5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lo !== 32'h0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore lo=%h busy=%b done=%b expected 0 1 0", lo, busy, done);
        end
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (hi !== 32'h7 || lo !== 32'h9 || done !== 1'b1) begin
            errors++;
            $display("FAIL busy_complete hi=%h lo=%h done=%b expected 7 9 1", hi, lo, done);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        issue(F_MFHI, 32'h0);
        mulIn = 64'h1;
        issue(F_MADDU, 32'h0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({hi, lo, dataOut, mulSignal, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid hi=%h lo=%h dout=%h ms=%b busy=%b done=%b expected all 0",
                     hi, lo, dataOut, mulSignal, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(F_MULTU, 32'h0);
        checks++;
        if (mulSignal !== F_MULTU || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_load ms=%b busy=%b expected 011001 1", mulSignal, busy);
        end
        mulIn = 64'd12;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'd12 || cyc != 36) begin
            errors++;
            $display("FAIL restart_mul hi=%h lo=%h cycles=%0d expected 0 c 36", hi, lo, cyc);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_mul(F_MULTU, 64'h1234_5678_9ABC_DEF0, cyc);
        start = 1'b1;
        Signal = F_MFLO;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (dataOut !== 32'h9ABC_DEF0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back dout=%h done=%b busy=%b expected 9abcdef0 1 0", dataOut, done, busy);
        end
    endtask

    task automatic test_msubu;
        int cyc;
        issue(F_MTHI, 32'h0);
        issue(F_MTLO, 32'd10);
`ifdef HILO_MSUB_EN
        run_mul(F_MSUBU, 64'd3, cyc);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd7) begin
            errors++;
            $display("FAIL msubu hi=%h lo=%h expected 0 7", hi, lo);
        end
        run_mul(F_MSUBU, 64'd8, cyc);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL msubu_borrow hi=%h lo=%h expected ffffffff ffffffff", hi, lo);
        end
`else
        mulIn = 64'd3;
        issue(F_MSUBU, 32'h0);
        checks++;
        if (busy !== 1'b0 || lo !== 32'd10 || done !== 1'b0 || mulSignal !== 6'b0) begin
            errors++;
            $display("FAIL msubu_ignored busy=%b lo=%h done=%b ms=%b expected 0 a 0 0", busy, lo, done, mulSignal);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lo !== 32'd10 || hi !== 32'h0) begin
            errors++;
            $display("FAIL msubu_idle busy=%b hi=%h lo=%h expected 0 0 a", busy, hi, lo);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mt_maddu();
        test_mf();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_msubu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
